mem_req_initiator: RTL and testbench

- Initiator-side counterpart of the external BRAM wrapper: turns a simple client load/store handshake into the packed 70-bit memory link and collects the responses.
- Drives the link's arg bus; receives its out bus.
- Tracks outstanding requests with a credit counter and buffers responses in a small FIFO so the client may back-pressure.
- Sits between a Kôika-generated core port (imem or dmem) and the memory wrapper.

---
 rtl/mem_link_pkg.sv | 23 ++
 rtl/mem_req_initiator_chk.sv | 21 ++
 rtl/mem_resp_fifo.sv | 61 ++++++
 rtl/mem_req_initiator.sv | 136 +++++++++++++
 tb/tb_mem_req_initiator.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_link_pkg.sv
// Shared definitions for the packed 70-bit memory link: field widths, the request/response
// record and the bit positions of the handshake flags inside the arg/out buses.
package mem_link_pkg;

    localparam int MEM_BE_W   = 4;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_REQ_W  = 68;
    localparam int MEM_LINK_W = 70;

    // arg bus = {get_valid, put_valid, put_request}; out bus = {get_ready, put_ready, get_response}
    localparam int GET_VALID_BIT = 69;
    localparam int PUT_VALID_BIT = 68;
    localparam int GET_READY_BIT = 69;
    localparam int PUT_READY_BIT = 68;

    typedef struct packed {
        logic [MEM_BE_W-1:0]   byte_en;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

endpackage

// File: rtl/mem_req_initiator_chk.sv
// Simulation-only link sanity check, present only with MEM_REQ_INITIATOR_STATS_EN defined:
// reports any response fire that happens with no request in flight.
`ifdef MEM_REQ_INITIATOR_STATS_EN
module mem_req_initiator_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             resp_fire,
    input logic [CNT_W-1:0] outstanding
);

    // Report an orphan response on the edge where it is taken.
    always @(posedge clk) begin
        if (!rst && resp_fire && (outstanding == '0)) begin
            $display("mem_req_initiator: response fire with no outstanding request");
        end
    end

endmodule
`endif

// File: rtl/mem_resp_fifo.sv
// Small response FIFO; pointers carry an extra wrap bit so full and empty fall out of a
// plain pointer compare. DEPTH must be a power of two and at least 2.
module mem_resp_fifo
    import mem_link_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = mem_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     wdata,
    output T     rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    T              mem_q [DEPTH];

    // Status flags, head of queue and next pointer values.
    always_comb begin
        full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty = (wptr_q == rptr_q);
        rdata = mem_q[rptr_q[AW-1:0]];
        if (push && !full) begin
            wptr_d = wptr_q + PW'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mem_req_initiator.sv
// Client load/store handshake to packed 70-bit memory link, with credit-limited requests and
// a buffered response path. MEM_REQ_INITIATOR_STATS_EN adds stat_* counters and a link check.
module mem_req_initiator
    import mem_link_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int RESP_DEPTH      = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [MEM_BE_W-1:0]   req_byte_en,
    input  logic [MEM_ADDR_W-1:0] req_addr,
    input  logic [MEM_DATA_W-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [MEM_BE_W-1:0]   resp_byte_en,
    output logic [MEM_ADDR_W-1:0] resp_addr,
    output logic [MEM_DATA_W-1:0] resp_data,
    output logic [MEM_LINK_W-1:0] mem_arg,
    input  logic [MEM_LINK_W-1:0] mem_out,
`ifdef MEM_REQ_INITIATOR_STATS_EN
    output logic [31:0]           stat_reqs,
    output logic [31:0]           stat_resps,
    output logic [31:0]           stat_stall,
`endif
    output logic                  busy
);

    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    mem_req_t         put_request_s, get_response_s, head_s;
    logic             put_ready_s, get_ready_s, credit_ok_s;
    logic             put_valid_s, get_valid_s;
    logic             req_fire_s, resp_fire_s, pop_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;

    // Handshakes are combinational and gated by RST so nothing fires during reset.
    always_comb begin
        put_request_s  = '{byte_en: req_byte_en, addr: req_addr, data: req_data};
        get_response_s = mem_req_t'(mem_out[MEM_REQ_W-1:0]);
        put_ready_s    = mem_out[PUT_READY_BIT];
        get_ready_s    = mem_out[GET_READY_BIT];
        credit_ok_s    = (outstanding_q < MAX_CNT);
        put_valid_s    = req_valid && credit_ok_s && !RST;
        req_ready      = put_ready_s && credit_ok_s && !RST;
        get_valid_s    = (outstanding_q != '0) && !fifo_full_s && !RST;
        req_fire_s     = put_valid_s && put_ready_s;
        resp_fire_s    = get_valid_s && get_ready_s;
        resp_valid     = !fifo_empty_s;
        pop_s          = resp_valid && resp_ready;
        resp_byte_en   = head_s.byte_en;
        resp_addr      = head_s.addr;
        resp_data      = head_s.data;
        busy           = (outstanding_q != '0) || !fifo_empty_s;
        mem_arg                  = '0;
        mem_arg[GET_VALID_BIT]   = get_valid_s;
        mem_arg[PUT_VALID_BIT]   = put_valid_s;
        mem_arg[MEM_REQ_W-1:0]   = put_request_s;
    end

    // Credit counter: a request and a response in the same cycle cancel out.
    always_comb begin
        case ({req_fire_s, resp_fire_s})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Credit register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    mem_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (mem_req_t)
    ) u_resp_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (resp_fire_s),
        .pop   (pop_s),
        .wdata (get_response_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef MEM_REQ_INITIATOR_STATS_EN
    logic [31:0] stat_reqs_q, stat_reqs_d;
    logic [31:0] stat_resps_q, stat_resps_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Free-running wrapping event counters.
    always_comb begin
        stat_reqs_d  = stat_reqs_q + {31'd0, req_fire_s};
        stat_resps_d = stat_resps_q + {31'd0, resp_fire_s};
        stat_stall_d = stat_stall_q + {31'd0, (req_valid && !req_ready)};
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_reqs_q  <= 32'd0;
            stat_resps_q <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            stat_reqs_q  <= stat_reqs_d;
            stat_resps_q <= stat_resps_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_reqs  = stat_reqs_q;
    assign stat_resps = stat_resps_q;
    assign stat_stall = stat_stall_q;

    mem_req_initiator_chk #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk         (CLK),
        .rst         (RST),
        .resp_fire   (resp_fire_s),
        .outstanding (outstanding_q)
    );
`endif

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench for mem_req_initiator: a queue-based model is compared on every falling edge,
// and hand-computed literals pin the key scenarios.
module tb_mem_req_initiator;
    import mem_link_pkg::*;

    localparam int MAXO  = 4;
    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic        put_ready = 1'b0;
    logic        get_ready = 1'b0;
    logic [3:0]  req_byte_en = 4'h0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    mem_req_t    get_resp = '0;
    logic        req_ready, resp_valid, busy;
    logic [3:0]  resp_byte_en;
    logic [31:0] resp_addr, resp_data;
    logic [69:0] mem_arg, mem_out;
`ifdef MEM_REQ_INITIATOR_STATS_EN
    logic [31:0] stat_reqs, stat_resps, stat_stall;
`endif

    int tests = 0;
    int fails = 0;

    assign mem_out = {get_ready, put_ready, get_resp};

    always #5 CLK = ~CLK;

    mem_req_initiator #(.MAX_OUTSTANDING(MAXO), .RESP_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_byte_en(req_byte_en),
        .req_addr(req_addr), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_byte_en(resp_byte_en),
        .resp_addr(resp_addr), .resp_data(resp_data),
        .mem_arg(mem_arg), .mem_out(mem_out),
`ifdef MEM_REQ_INITIATOR_STATS_EN
        .stat_reqs(stat_reqs), .stat_resps(stat_resps), .stat_stall(stat_stall),
`endif
        .busy(busy)
    );

    task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mem_req_t mk(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
        mk = '{byte_en: be, addr: a, data: d};
    endfunction

    // Model state: credits in flight and the client-visible response queue.
    int       m_out = 0;
    mem_req_t m_q[$];
    bit       cok, e_pv, e_rr, e_gv, e_rv, rf, gf;

    always @(negedge CLK) begin
        cok  = (m_out < MAXO);
        e_pv = req_valid && cok && !RST;
        e_rr = put_ready && cok && !RST;
        e_gv = (m_out != 0) && (m_q.size() < DEPTH) && !RST;
        e_rv = (m_q.size() != 0);
        chk("m_put_valid", 70'(mem_arg[68]), 70'(e_pv));
        chk("m_get_valid", 70'(mem_arg[69]), 70'(e_gv));
        chk("m_req_ready", 70'(req_ready), 70'(e_rr));
        chk("m_put_request", 70'(mem_arg[67:0]), 70'({req_byte_en, req_addr, req_data}));
        chk("m_resp_valid", 70'(resp_valid), 70'(e_rv));
        chk("m_busy", 70'(busy), 70'((m_out != 0) || e_rv));
        if (e_rv) chk("m_resp_head", 70'({resp_byte_en, resp_addr, resp_data}), 70'(m_q[0]));
        rf = e_pv && put_ready;
        gf = e_gv && get_ready;
        if (e_rv && resp_ready) m_q.delete(0);
        if (gf) m_q.push_back(get_resp);
        m_out = m_out + int'(rf) - int'(gf);
        if (RST) begin
            m_out = 0;
            m_q.delete();
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        req_valid  = 1'b0;
        get_ready  = 1'b1;
        resp_ready = 1'b1;
        get_resp   = mk(4'h0, 32'hD0, 32'hD0D0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (!busy) break;
            step();
        end
        chk("drain_idle", 70'(busy), 70'(1'b0));
        step();
        get_ready  = 1'b0;
        resp_ready = 1'b0;
    endtask

    int n;

    initial begin
        // Reset with a request pending: handshakes must stay gated.
        req_valid = 1'b1;
        put_ready = 1'b1;
        step();
        @(negedge CLK);
        chk("rst_valids", 70'(mem_arg[69:68]), 70'(2'b00));
        chk("rst_req_ready", 70'(req_ready), 70'(1'b0));
        step();
        RST = 1'b0;
        req_valid = 1'b0;
        @(negedge CLK);
        chk("rst_resp_valid", 70'(resp_valid), 70'(1'b0));
        chk("rst_busy", 70'(busy), 70'(1'b0));
        step();

        // Single load answered two cycles later.
        req_valid = 1'b1; req_byte_en = 4'h0; req_addr = 32'h100; req_data = 32'h0;
        @(negedge CLK);
        chk("ld_put_valid", 70'(mem_arg[68]), 70'(1'b1));
        chk("ld_put_request", 70'(mem_arg[67:0]), 70'(68'h0_00000100_00000000));
        step();
        req_valid = 1'b0;
        @(negedge CLK);
        chk("ld_get_valid", 70'(mem_arg[69]), 70'(1'b1));
        step();
        get_ready = 1'b1; get_resp = mk(4'h0, 32'h100, 32'hDEADBEEF);
        @(negedge CLK);
        chk("ld_no_bypass", 70'(resp_valid), 70'(1'b0));
        step();
        get_ready = 1'b0; resp_ready = 1'b1;
        @(negedge CLK);
        chk("ld_resp_valid", 70'(resp_valid), 70'(1'b1));
        chk("ld_resp_data", 70'(resp_data), 70'(32'hDEADBEEF));
        chk("ld_resp_addr", 70'(resp_addr), 70'(32'h100));
        step();
        resp_ready = 1'b0;
        @(negedge CLK);
        chk("ld_busy_drop", 70'(busy), 70'(1'b0));
        step();

        // Credit limit with the memory withholding responses.
        n = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_addr = 32'h200 + 32'(4 * i);
            @(negedge CLK);
            if (req_ready) n++;
            step();
        end
        @(negedge CLK);
        chk("cr_fires", 70'(n), 70'(4));
        chk("cr_ready_low", 70'(req_ready), 70'(1'b0));
        step();
        req_valid = 1'b0; get_ready = 1'b1; get_resp = mk(4'h0, 32'h200, 32'h2);
        step();
        get_ready = 1'b0;
        @(negedge CLK);
        chk("cr_ready_back", 70'(req_ready), 70'(1'b1));
        step();
        drain();

        // Back-pressure: three loads, two buffer slots.
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(4 * i);
            step();
        end
        req_valid = 1'b0; get_ready = 1'b1;
        get_resp = mk(4'h0, 32'h0, 32'hA0);
        step();
        get_resp = mk(4'h0, 32'h4, 32'hA4);
        step();
        get_resp = mk(4'h0, 32'h8, 32'hA8);
        @(negedge CLK);
        chk("bp_get_blocked", 70'(mem_arg[69]), 70'(1'b0));
        chk("bp_head0", 70'(resp_addr), 70'(32'h0));
        step();
        resp_ready = 1'b1;
        @(negedge CLK);
        chk("bp_full_registered", 70'(mem_arg[69]), 70'(1'b0));
        step();
        @(negedge CLK);
        chk("bp_get_resumes", 70'(mem_arg[69]), 70'(1'b1));
        chk("bp_head1", 70'(resp_addr), 70'(32'h4));
        step();
        @(negedge CLK);
        chk("bp_head2", 70'(resp_addr), 70'(32'h8));
        chk("bp_head2_data", 70'(resp_data), 70'(32'hA8));
        step();
        get_ready = 1'b0; resp_ready = 1'b0;
        @(negedge CLK);
        chk("bp_idle", 70'(busy), 70'(1'b0));
        step();

        // Simultaneous request and response fire with two outstanding.
        resp_ready = 1'b1; req_valid = 1'b1;
        req_addr = 32'h300; step();
        req_addr = 32'h304; step();
        req_addr = 32'h308; get_ready = 1'b1; get_resp = mk(4'h0, 32'h300, 32'h33);
        @(negedge CLK);
        chk("sim_req_ready", 70'(req_ready), 70'(1'b1));
        chk("sim_get_valid", 70'(mem_arg[69]), 70'(1'b1));
        step();
        get_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h30C + 32'(4 * i);
            @(negedge CLK);
            if (req_ready) n++;
            step();
        end
        chk("sim_credits_left", 70'(n), 70'(2));
        drain();

        // Store.
        req_valid = 1'b1; put_ready = 1'b1;
        req_byte_en = 4'hF; req_addr = 32'h20; req_data = 32'h12345678;
        @(negedge CLK);
        chk("st_put_request", 70'(mem_arg[67:0]), 70'(68'hF_00000020_12345678));
        step();
        req_valid = 1'b0; req_byte_en = 4'h0;
        get_ready = 1'b1; get_resp = mk(4'hF, 32'h20, 32'h12345678);
        step();
        get_ready = 1'b0; resp_ready = 1'b1;
        @(negedge CLK);
        chk("st_resp_be", 70'(resp_byte_en), 70'(4'hF));
        chk("st_resp_data", 70'(resp_data), 70'(32'h12345678));
        step();
        resp_ready = 1'b0;
        @(negedge CLK);
        chk("st_idle", 70'(busy), 70'(1'b0));
        step();

        // Reset mid-flight: three outstanding, one buffered.
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = 32'h400 + 32'(4 * i);
            step();
        end
        req_valid = 1'b0; get_ready = 1'b1; get_resp = mk(4'h0, 32'h400, 32'h44);
        step();
        get_ready = 1'b0;
        @(negedge CLK);
        chk("mr_buffered", 70'(resp_valid), 70'(1'b1));
        step();
        RST = 1'b1;
        @(negedge CLK);
        chk("mr_rst_gate", 70'(mem_arg[69]), 70'(1'b0));
        step();
        RST = 1'b0; req_valid = 1'b1; req_addr = 32'h500;
        @(negedge CLK);
        chk("mr_resp_valid", 70'(resp_valid), 70'(1'b0));
        chk("mr_busy", 70'(busy), 70'(1'b0));
        chk("mr_get_valid", 70'(mem_arg[69]), 70'(1'b0));
        chk("mr_req_ready", 70'(req_ready), 70'(1'b1));
        step();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
